// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and parity modes.
// Imported by uart_tx, uart_baud_gen and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx_if.sv
// Read port of the TX FIFO as seen by the transmitter.
// The transmitter is the master: it issues read strobes and receives registered data.
interface uart_tx_if;

    logic       fifo_rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_data
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 while not cleared; bit_end flags the final clock of each period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: clocked state is written only with non-blocking assignments so every
    // reader in the same edge sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and frames them as
// start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      tx_en,
    uart_tx_if.master fifo,
    output logic      tx,
    output logic      busy,
    output logic      tx_done
);

    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != PAR_NONE);
    localparam bit ODD_PARITY = (PARITY == PAR_ODD);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic [IW-1:0]        bit_idx;
    logic                 rd_en_q;
    logic                 bit_end;
    logic                 baud_clr;

    // The bit timer only runs once a byte has been committed to the shifter.
    assign baud_clr = (state == ST_IDLE) || (state == ST_REQ) || (state == ST_LOAD);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (baud_clr),
        .bit_end (bit_end)
    );

    assign fifo.fifo_rd_en = rd_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            rd_en_q <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
            shift   <= '0;
            par_acc <= 1'b0;
            bit_idx <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only in the
            // branch that needs them, so no path leaves them holding a stale 1.
            rd_en_q <= 1'b0;
            tx_done <= 1'b0;

            // The line is a registered image of the state, trailing it by one clock.
            case (state)
                ST_START:  tx <= 1'b0;
                ST_DATA:   tx <= shift[0];
                ST_PARITY: tx <= ODD_PARITY ? ~par_acc : par_acc;
                default:   tx <= 1'b1;
            endcase

            case (state)
                ST_IDLE: begin
                    if (tx_en && !fifo.fifo_empty) begin
                        state   <= ST_REQ;
                        rd_en_q <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift   <= fifo.fifo_data[DATA_BITS-1:0];
                    par_acc <= 1'b0;
                    bit_idx <= '0;
                    state   <= ST_START;
                end
                ST_START: begin
                    if (bit_end) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        par_acc <= par_acc ^ shift[0];
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
                            state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    // bit_idx is reused to count stop-bit periods.
                    if (bit_end) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: 8N1 instance fed by a small FIFO
// model, plus even- and odd-parity 8-bit/2-stop instances fed a constant 0x55.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;
    logic tx_en, en_e, en_o;
    logic par_empty_e, par_empty_o;
    logic tx, busy, tx_done;
    logic tx_e, busy_e, done_e;
    logic tx_o, busy_o, done_o;

    int errors = 0;
    int checks = 0;

    uart_tx_if bus ();
    uart_tx_if bus_e ();
    uart_tx_if bus_o ();

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo(bus.master),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_e (
        .clk(clk), .rst(rst), .tx_en(en_e), .fifo(bus_e.master),
        .tx(tx_e), .busy(busy_e), .tx_done(done_e)
    );

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_o (
        .clk(clk), .rst(rst), .tx_en(en_o), .fifo(bus_o.master),
        .tx(tx_o), .busy(busy_o), .tx_done(done_o)
    );

    always #5 clk = ~clk;

    // FIFO model: initial block pushes, clocked block pops with one-cycle read latency.
    logic [7:0] mem [32];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_pulses = 0;
    int rd_empty = 0;
    int done_cnt = 0;
    int rd_e_cnt = 0;
    int rd_o_cnt = 0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus_e.fifo_empty = par_empty_e;
    assign bus_e.fifo_data  = 8'h55;
    assign bus_o.fifo_empty = par_empty_o;
    assign bus_o.fifo_data  = 8'h55;

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
        if (bus.fifo_rd_en) rd_pulses <= rd_pulses + 1;
        if (bus.fifo_rd_en && bus.fifo_empty) rd_empty <= rd_empty + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (bus_e.fifo_rd_en) rd_e_cnt <= rd_e_cnt + 1;
        if (bus_o.fifo_rd_en) rd_o_cnt <= rd_o_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_line(input int sel);
        return (sel == 0) ? tx : (sel == 1) ? tx_e : tx_o;
    endfunction

    function automatic logic cur_done(input int sel);
        return (sel == 0) ? tx_done : (sel == 1) ? done_e : done_o;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel == 0) ? busy : (sel == 1) ? busy_e : busy_o;
    endfunction

    // Clocks from the current negedge until the line is seen low; -1 on timeout.
    task automatic wait_fall(input int sel, output int gap);
        gap = 0;
        while (cur_line(sel) !== 1'b0 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 200) gap = -1;
    endtask

    // Samples nbits bit periods starting at the start-bit negedge; bits[0] is the start bit.
    task automatic capture(input int sel, input int nbits, input int drop_at,
                           output logic [15:0] bits, output int glitches,
                           output int done_idx, output logic done_busy);
        int k;
        bits = '0;
        glitches = 0;
        done_idx = -1;
        done_busy = 1'bx;
        for (int p = 0; p < nbits; p++) begin
            for (int c = 0; c < 4; c++) begin
                k = p * 4 + c;
                if (k == drop_at) tx_en = 1'b0;
                if (c == 0) bits[p] = cur_line(sel);
                else if (cur_line(sel) !== bits[p]) glitches++;
                if (cur_done(sel) === 1'b1) begin
                    done_idx = k;
                    done_busy = cur_busy(sel);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int gap, glitches, done_idx;
        logic [15:0] bits;
        logic done_busy;
        logic any_rd, any_low, any_busy;

        rst = 1'b1;
        tx_en = 1'b0;
        en_e = 1'b0;
        en_o = 1'b0;
        par_empty_e = 1'b1;
        par_empty_o = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", bus.fifo_rd_en, 1'b0);
        check("rst_tx_done", tx_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single 0x55 frame.
        push(8'h55);
        tx_en = 1'b1;
        @(negedge clk);
        check("t1_rd_en_pulse", bus.fifo_rd_en, 1'b1);
        wait_fall(0, gap);
        check("t1_latency", gap, 3);
        capture(0, 10, -1, bits, glitches, done_idx, done_busy);
        check("t1_frame", bits, 16'h02AA);
        check("t1_glitches", glitches, 0);
        check("t1_done_idx", done_idx, 39);
        check("t1_done_busy", done_busy, 1'b0);
        check("t1_rd_pulses", rd_pulses, 1);
        check("t1_done_cnt", done_cnt, 1);

        // Back-to-back 0xA3, 0x0F.
        push(8'hA3);
        push(8'h0F);
        @(negedge clk);
        wait_fall(0, gap);
        check("t2_latency", gap, 3);
        capture(0, 10, -1, bits, glitches, done_idx, done_busy);
        check("t2_frame_a3", bits, 16'h0346);
        check("t2_glitches_a3", glitches, 0);
        wait_fall(0, gap);
        check("t2_gap", gap, 3);
        capture(0, 10, -1, bits, glitches, done_idx, done_busy);
        check("t2_frame_0f", bits, 16'h021E);
        check("t2_glitches_0f", glitches, 0);
        check("t2_rd_pulses", rd_pulses, 3);
        check("t2_done_cnt", done_cnt, 3);

        // Empty FIFO with tx_en held high.
        any_rd = 1'b0;
        any_low = 1'b0;
        any_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.fifo_rd_en !== 1'b0) any_rd = 1'b1;
            if (tx !== 1'b1) any_low = 1'b1;
            if (busy !== 1'b0) any_busy = 1'b1;
            @(negedge clk);
        end
        check("t3_no_rd", any_rd, 1'b0);
        check("t3_line_high", any_low, 1'b0);
        check("t3_not_busy", any_busy, 1'b0);

        // tx_en dropped during bit 3 of 0xC4 with 0x3C still queued.
        push(8'hC4);
        push(8'h3C);
        @(negedge clk);
        wait_fall(0, gap);
        check("t4_latency", gap, 3);
        capture(0, 10, 17, bits, glitches, done_idx, done_busy);
        check("t4_frame_c4", bits, 16'h0388);
        check("t4_glitches", glitches, 0);
        any_rd = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fifo_rd_en !== 1'b0) any_rd = 1'b1;
            if (tx !== 1'b1) any_low = 1'b1;
            @(negedge clk);
        end
        check("t4_no_rd_disabled", any_rd, 1'b0);
        check("t4_idle_high", any_low, 1'b0);
        check("t4_rd_pulses_hold", rd_pulses, 4);
        tx_en = 1'b1;
        @(negedge clk);
        wait_fall(0, gap);
        check("t4_restart_latency", gap, 3);
        capture(0, 10, -1, bits, glitches, done_idx, done_busy);
        check("t4_frame_3c", bits, 16'h0278);
        check("t4_rd_pulses", rd_pulses, 5);

        // Reset during data bit 5 of 0x96 (bit 5 is 0), then 0x5A sent cleanly.
        push(8'h96);
        push(8'h5A);
        @(negedge clk);
        wait_fall(0, gap);
        check("t5_latency", gap, 3);
        repeat (25) @(negedge clk);
        check("t5_pre_rst_line", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rd_en", bus.fifo_rd_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_fall(0, gap);
        check("t5_restart_latency", gap, 3);
        capture(0, 10, -1, bits, glitches, done_idx, done_busy);
        check("t5_frame_5a", bits, 16'h02B4);
        check("t5_glitches", glitches, 0);
        check("t5_rd_pulses", rd_pulses, 7);
        check("t5_done_cnt", done_cnt, 6);
        check("no_empty_reads", rd_empty, 0);

        // Even parity, two stop bits, 0x55.
        en_e = 1'b1;
        par_empty_e = 1'b0;
        @(negedge clk);
        par_empty_e = 1'b1;
        wait_fall(1, gap);
        check("even_latency", gap, 3);
        en_e = 1'b0;
        capture(1, 12, -1, bits, glitches, done_idx, done_busy);
        check("even_frame", bits, 16'h0CAA);
        check("even_glitches", glitches, 0);
        check("even_done_idx", done_idx, 47);
        check("even_rd_pulses", rd_e_cnt, 1);

        // Odd parity, two stop bits, 0x55.
        en_o = 1'b1;
        par_empty_o = 1'b0;
        @(negedge clk);
        par_empty_o = 1'b1;
        wait_fall(2, gap);
        check("odd_latency", gap, 3);
        en_o = 1'b0;
        capture(2, 12, -1, bits, glitches, done_idx, done_busy);
        check("odd_frame", bits, 16'h0EAA);
        check("odd_glitches", glitches, 0);
        check("odd_done_idx", done_idx, 47);
        check("odd_rd_pulses", rd_o_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
